// File: rtl/sram_stream_reader.sv
// Read-side stream master for the multi-channel Sram: walks an address range, absorbs the 1-cycle
// read latency in a 2-entry FIFO, emits valid/ready words. Optional macro: SRAM_STREAM_BOUNDS_CHECK_EN.
module sram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int CHANNEL    = 2,
    parameter int SIZE       = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH:0]            len,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [CHANNEL-1:0]             rd_en,
    output logic [CHANNEL*ADDR_WIDTH-1:0]  rd_addr,
    input  logic [CHANNEL*DATA_WIDTH-1:0]  rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNEL*DATA_WIDTH-1:0]  out_data,
    output logic                           out_last
);

    localparam logic [ADDR_WIDTH:0]   SIZE_W    = (ADDR_WIDTH+1)'(SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                        state;
    logic [ADDR_WIDTH-1:0]         cur_addr;
    logic [ADDR_WIDTH:0]           len_r;
    logic [ADDR_WIDTH:0]           issue_cnt;
    logic                          inflight;
    logic                          inflight_last;
    logic [CHANNEL*DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]                    fifo_last;
    logic                          wr_ptr;
    logic                          rd_ptr;
    logic [1:0]                    fifo_count;
    logic                          issue;
    logic                          pop;
    logic                          range_bad;
    logic                          last_issue;
    logic [1:0]                    occupancy;

`ifdef SRAM_STREAM_BOUNDS_CHECK_EN
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] b, input logic [ADDR_WIDTH:0] l);
        logic [ADDR_WIDTH:0] end_addr;
        end_addr = {1'b0, b} + l;
        return ({1'b0, b} >= SIZE_W) || (end_addr > SIZE_W);
    endfunction
    assign range_bad = out_of_range(base_addr, len);
`else
    assign range_bad = 1'b0;
`endif

    // Credit counts words already queued or still in the Sram pipe; a pop this cycle frees a slot.
    assign pop        = out_valid & out_ready;
    assign occupancy  = fifo_count + {1'b0, inflight} - {1'b0, pop};
    assign issue      = (state == RUN) && (occupancy < 2'd2);
    assign last_issue = (issue_cnt == len_r - 1'b1);

    assign rd_en     = {CHANNEL{issue}};
    assign rd_addr   = {CHANNEL{cur_addr}};
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid & fifo_last[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            len_r     <= '0;
            issue_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        err  <= range_bad;
                        if (len == '0 || range_bad) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            cur_addr  <= ADDR_WIDTH'({1'b0, base_addr} % SIZE_W);
                            len_r     <= len;
                            issue_cnt <= '0;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        cur_addr  <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
                        issue_cnt <= issue_cnt + 1'b1;
                        if (last_issue) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (occupancy == 2'd0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sram latency stage: a read issued last cycle returns its data now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue & last_issue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_count   <= '0;
        end else begin
            if (inflight) begin
                fifo_data[wr_ptr] <= rd_data;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader with a 2-bank Sram model (1-cycle read latency).
module tb_sram_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  len;
    logic        busy, done, err;
    logic [1:0]  rd_en;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    int n_assert = 0;
    int n_fail   = 0;

    sram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CHANNEL(2), .SIZE(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [2][16];
    initial rd_data = '0;
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++)
            if (rd_en[c]) rd_data[c*8 +: 8] <= mem[c][rd_addr[c*8 +: 4]];
    end

    int          cyc = 0;
    logic [16:0] word_q[$];
    logic [15:0] addr_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_hs_cyc = 0;
    int          valid_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            word_q.push_back({out_last, out_data});
            last_hs_cyc = cyc;
        end
        if (rd_en != 2'b00) addr_q.push_back(rd_addr);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid) valid_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        word_q.delete();
        addr_q.delete();
        done_cnt  = 0;
        valid_cnt = 0;
    endtask

    task automatic pulse_start(input logic [7:0] b, input logic [8:0] l);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 60) begin
            tick();
            k++;
        end
        chk(tag, {31'b0, done}, 32'd1);
    endtask

    task automatic chk_words(input string tag, input int n, input int b);
        logic [7:0]  a;
        logic [16:0] exp;
        chk({tag, "_count"}, word_q.size(), n);
        for (int i = 0; i < n && i < word_q.size(); i++) begin
            a   = 8'((b + i) % 16);
            exp = {(i == n - 1), 8'h80 + a, a};
            chk($sformatf("%s_word%0d", tag, i), {15'b0, word_q[i]}, {15'b0, exp});
        end
    endtask

    task automatic chk_addrs(input string tag, input int n, input int b);
        logic [7:0] a;
        chk({tag, "_nrd"}, addr_q.size(), n);
        for (int i = 0; i < n && i < addr_q.size(); i++) begin
            a = 8'((b + i) % 16);
            chk($sformatf("%s_addr%0d", tag, i), {16'b0, addr_q[i]}, {16'b0, a, a});
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[0][i] = 8'(i);
            mem[1][i] = 8'(8'h80 + i);
        end
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_rd_en", {30'b0, rd_en}, 0);
        chk("rst_rd_addr", {16'b0, rd_addr}, 0);
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_data", {16'b0, out_data}, 0);
        chk("rst_last", {31'b0, out_last}, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: full-throughput transfer with exact latency.
        clear_logs();
        pulse_start(8'd2, 9'd4);
        chk("t1_busy", {31'b0, busy}, 1);
        chk("t1_rd_en_first", {30'b0, rd_en}, 32'h3);
        chk("t1_rd_addr_first", {16'b0, rd_addr}, 32'h0202);
        tick();
        chk("t1_valid_t1", {31'b0, out_valid}, 0);
        tick();
        chk("t1_valid_t2", {31'b0, out_valid}, 1);
        chk("t1_data_t2", {16'b0, out_data}, 32'h8202);
        wait_done("t1_done");
        tick();
        chk("t1_busy_after", {31'b0, busy}, 0);
        chk_words("t1", 4, 2);
        chk_addrs("t1", 4, 2);
        chk("t1_done_lat", done_cyc, last_hs_cyc + 1);
        chk("t1_done_cnt", done_cnt, 1);

        // Test 2: backpressure for 5 cycles after first valid.
        clear_logs();
        out_ready = 1'b0;
        pulse_start(8'd2, 9'd4);
        for (int k = 0; k < 10 && !out_valid; k++) tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_hold%0d", k), {16'b0, out_data}, 32'h8202);
            tick();
        end
        chk("t2_nrd_stalled", addr_q.size(), 2);
        chk("t2_valid_stalled", {31'b0, out_valid}, 1);
        out_ready = 1'b1;
        wait_done("t2_done");
        tick();
        chk_words("t2", 4, 2);
        chk_addrs("t2", 4, 2);

`ifdef SRAM_STREAM_BOUNDS_CHECK_EN
        // Test 4: out-of-range start is rejected, then cleared by a legal start.
        clear_logs();
        pulse_start(8'd14, 9'd4);
        chk("t4_done", {31'b0, done}, 1);
        chk("t4_err", {31'b0, err}, 1);
        tick(); tick();
        chk("t4_err_sticky", {31'b0, err}, 1);
        chk("t4_nrd", addr_q.size(), 0);
        chk("t4_nvalid", valid_cnt, 0);
        clear_logs();
        pulse_start(8'd0, 9'd1);
        chk("t4_err_clr", {31'b0, err}, 0);
        wait_done("t4_done2");
        tick();
        chk_words("t4", 1, 0);
`else
        // Test 3: address wrap from SIZE-1 to 0.
        clear_logs();
        pulse_start(8'd14, 9'd4);
        wait_done("t3_done");
        tick();
        chk("t3_err", {31'b0, err}, 0);
        chk_words("t3", 4, 14);
        chk_addrs("t3", 4, 14);
`endif

        // Test 5: len=0, then a start while busy is ignored.
        clear_logs();
        pulse_start(8'd3, 9'd0);
        chk("t5_done_len0", {31'b0, done}, 1);
        tick();
        chk("t5_done_drop", {31'b0, done}, 0);
        tick();
        chk("t5_nrd_len0", addr_q.size(), 0);
        chk("t5_nvalid_len0", valid_cnt, 0);
        clear_logs();
        pulse_start(8'd2, 9'd4);
        tick();
        pulse_start(8'd8, 9'd3);
        wait_done("t5_done");
        tick(); tick(); tick();
        chk_words("t5", 4, 2);
        chk("t5_done_cnt", done_cnt, 1);

        // Test 6: reset mid-transfer, then a clean run.
        clear_logs();
        pulse_start(8'd0, 9'd8);
        for (int k = 0; k < 30 && word_q.size() < 2; k++) tick();
        chk("t6_pre_rst_words", word_q.size(), 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {31'b0, busy}, 0);
        chk("t6_rst_rd_en", {30'b0, rd_en}, 0);
        chk("t6_rst_valid", {31'b0, out_valid}, 0);
        chk("t6_rst_data", {16'b0, out_data}, 0);
        chk("t6_rst_last", {31'b0, out_last}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("t6_no_done", done_cnt, 0);
        clear_logs();
        pulse_start(8'd0, 9'd2);
        wait_done("t6_done");
        tick();
        chk_words("t6", 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
